bin2bcd_fmt: RTL
================

BIN2BCD_FMT -- requirements
Module: bin2bcd_fmt

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all logic on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-004 SHALL have port bin_in, input, 21 bits: signed two's-complement value, captured on start acceptance.
REQ-005 SHALL have port dp_pos, input, 3 bits: decimal places 0..5, captured with bin_in.
REQ-006 SHALL have port data_out, output, 24 bits: six display nibbles, [23:20] leftmost digit; 0..9 digit, 4'ha minus, 4'hf blank.
REQ-007 SHALL have port point, output, 6 bits: one-hot decimal-point enables, [5] leftmost digit.
REQ-008 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when data_out and point update.
REQ-010 SHALL have port ovf, output, 1 bit: registered flag, value outside displayable range.

Function
REQ-011 SHALL implement FSM IDLE -> ABS -> SHIFT -> FMT -> IDLE.
REQ-012 IDLE: start=1 at an edge SHALL capture bin_in and dp_pos, set busy, and move to ABS.
REQ-013 ABS (1 cycle) SHALL form a 21-bit unsigned magnitude and a sign flag; -1048576 SHALL give magnitude 2^20.
REQ-014 SHALL spend exactly 21 cycles in SHIFT, each doing add-3 on every BCD nibble >= 5, then a left shift of one magnitude bit into the BCD register.
REQ-015 FMT (1 cycle) SHALL register data_out, point, ovf, pulse done=1, clear busy, and return to IDLE.
REQ-016 Latency SHALL be fixed: done is high in the cycle after the 24th rising edge counting the accepting edge as 1; busy is high for 23 cycles.
REQ-017 start while busy SHALL be ignored, with no queuing.
REQ-018 start in the cycle where done=1 SHALL be accepted, giving back-to-back conversions.
REQ-019 Overflow is value > 999999 or value < -99999; it SHALL set ovf=1, data_out=24'haaaaaa, and point=0.
REQ-020 Any non-overflow result SHALL clear ovf.
REQ-021 dp_pos in 1..5 SHALL set point[dp_pos]=1 with all other bits 0; dp_pos of 0, 6 or 7 SHALL give point=0, and dp_pos 6 or 7 SHALL be treated as 0 for blanking.
REQ-022 Digit index i (0 = rightmost) with i <= dp_pos SHALL never be blanked.
REQ-023 A negative value SHALL place 4'ha in the digit immediately left of the highest displayed digit.
REQ-024 data_out, point and ovf SHALL hold their values between done pulses.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, busy=0, done=0, ovf=0, data_out=24'hffffff, point=0, and clear the internal BCD register and counter.
REQ-026 rst mid-conversion SHALL abort it with no done pulse, and no output SHALL be updated by the aborted conversion.
REQ-027 start asserted together with rst SHALL be ignored.

Configuration
REQ-028 Macro BIN2BCD_FMT_LZB_EN defined: leading-zero digits left of the most significant nonzero digit, excluding digits protected by REQ-022, SHALL be 4'hf.
REQ-029 Macro BIN2BCD_FMT_LZB_EN undefined: no blanking; all six digits SHALL be shown as digits, a negative value SHALL put 4'ha in digit 5, and timing SHALL be unchanged.

Verification (with BIN2BCD_FMT_LZB_EN unless noted)
REQ-030 bin_in=1234, dp_pos=0, start -> done 24 cycles later, data_out=24'hff1234, point=0, ovf=0; with the macro undefined -> data_out=24'h001234.
REQ-031 bin_in=-42, dp_pos=0 -> data_out=24'hfffa42; bin_in=5, dp_pos=2 -> data_out=24'hfff005, point=6'b000100.
REQ-032 bin_in=0, dp_pos=0 -> data_out=24'hfffff0; bin_in=999999 -> data_out=24'h999999, ovf=0.
REQ-033 bin_in=1000000 -> ovf=1, data_out=24'haaaaaa; bin_in=-100000 -> ovf=1; bin_in=-1048576 -> ovf=1.
REQ-034 start pulsed at cycles 0 and 5 -> exactly one done; start held high continuously -> done every 24 cycles.
REQ-035 rst at cycle 10 of a conversion -> no done pulse, outputs at their reset values, and the next start converts correctly.

Source files
------------

// File: rtl/bin2bcd_fmt.sv
// Signed 21-bit binary to six-digit display formatter (double-dabble, fixed 24-cycle latency).
// Define BIN2BCD_FMT_LZB_EN to blank leading zeros; undefined shows all six digits.
module bin2bcd_fmt (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [20:0] bin_in,
  input  logic [2:0]  dp_pos,
  output logic [23:0] data_out,
  output logic [5:0]  point,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ABS, S_SHIFT, S_FMT} state_t;

  state_t      state_q, state_d;
  logic [20:0] bin_q, bin_d;      // captured value, then magnitude shift register
  logic [2:0]  dp_q, dp_d;
  logic        neg_q, neg_d;
  logic [27:0] bcd_q, bcd_d;      // seven digits: 2^20 needs one beyond the display
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] data_q, data_d;
  logic [5:0]  point_q, point_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [23:0] fmt_data;
  logic [5:0]  fmt_point;
  logic        fmt_ovf;
  logic [2:0]  dp_eff;
`ifdef BIN2BCD_FMT_LZB_EN
  logic [2:0]  top;
  logic [2:0]  sign_pos;
`endif

  function automatic logic [27:0] bcd_step(input logic [27:0] b, input logic bit_in);
    logic [27:0] adj;
    adj = b;
    for (int k = 0; k < 7; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    return {adj[26:0], bit_in};
  endfunction

  // Display formatting from the finished BCD register, consumed in FMT.
  always_comb begin
    fmt_ovf   = (bcd_q[27:24] != 4'd0) || (neg_q && (bcd_q[23:20] != 4'd0));
    dp_eff    = (dp_q > 3'd5) ? 3'd0 : dp_q;
    fmt_point = '0;
    for (int i = 1; i < 6; i++) fmt_point[i] = (dp_eff == 3'(i));
    fmt_data  = bcd_q[23:0];
`ifdef BIN2BCD_FMT_LZB_EN
    top = dp_eff;
    for (int i = 1; i < 6; i++) begin
      if ((bcd_q[4*i +: 4] != 4'd0) && (3'(i) > top)) top = 3'(i);
    end
    // With five decimals the minus can only take digit 5, which is zero for any legal negative.
    sign_pos = (top == 3'd5) ? 3'd5 : top + 3'd1;
    for (int i = 0; i < 6; i++) begin
      if (3'(i) > top) fmt_data[4*i +: 4] = 4'hf;
      if (neg_q && (3'(i) == sign_pos)) fmt_data[4*i +: 4] = 4'ha;
    end
`else
    if (neg_q) fmt_data[23:20] = 4'ha;
`endif
    if (fmt_ovf) begin
      fmt_data  = 24'haaaaaa;
      fmt_point = '0;
    end
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    dp_d    = dp_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    point_d = point_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          dp_d    = dp_pos;
          busy_d  = 1'b1;
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        neg_d   = bin_q[20];
        bin_d   = bin_q[20] ? (21'd0 - bin_q) : bin_q;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d = bcd_step(bcd_q, bin_q[20]);
        bin_d = {bin_q[19:0], 1'b0};
        if (cnt_q == 5'd20) state_d = S_FMT;
        else                cnt_d   = cnt_q + 5'd1;
      end
      S_FMT: begin
        data_d  = fmt_data;
        point_d = fmt_point;
        ovf_d   = fmt_ovf;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      dp_q    <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      data_q  <= 24'hffffff;
      point_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      dp_q    <= dp_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      point_q <= point_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out = data_q;
  assign point    = point_q;
  assign ovf      = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
